// File: rtl/capiano_pkg.sv
// Shared camera-piano definitions.
// Holds the frame geometry, the RGB565 field positions, the key detector
// state type, and the luma helper used by the pixel classifier.
package capiano_pkg;

    localparam int PIX_W   = 16;
    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        KD_IDLE  = 2'd0,
        KD_COUNT = 2'd1,
        KD_EVAL  = 2'd2
    } kd_state_t;

    // Green is 6 bits and red/blue are 5, so red is doubled to weigh roughly
    // like green. The largest possible sum is 62 + 63 + 31 = 156.
    function automatic logic [7:0] rgb565_luma(input logic [PIX_W-1:0] p);
        return {2'b00, p[R_MSB:R_LSB], 1'b0}
             + {2'b00, p[G_MSB:G_LSB]}
             + {3'b000, p[B_MSB:B_LSB]};
    endfunction

endpackage

// File: rtl/key_detector_if.sv
// Pixel stream in / key results out for the key detector.
// master: the pixel source, which also consumes the key results.
// slave : the key detector.
//   pix_valid, pix_data, sof, eol, eof : RGB565 stream with frame/line markers
//   key_mask, key_onset, key_valid     : pressed keys, new presses, update strobe
//   debug_out                          : seven-segment debug word
interface key_detector_if #(
    parameter int NUM_KEYS = 8
);
    import capiano_pkg::*;

    logic                 pix_valid;
    logic [PIX_W-1:0]     pix_data;
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic [NUM_KEYS-1:0]  key_mask;
    logic [NUM_KEYS-1:0]  key_onset;
    logic                 key_valid;
    logic [15:0]          debug_out;

    modport master (
        output pix_valid, pix_data, sof, eol, eof,
        input  key_mask, key_onset, key_valid, debug_out
    );

    modport slave (
        input  pix_valid, pix_data, sof, eol, eof,
        output key_mask, key_onset, key_valid, debug_out
    );

endinterface

// File: rtl/key_detector_pix_classify.sv
// pix_classify: registered RGB565 luma and dark decision.
//   clk, rst          : clock, async active-low reset
//   in_valid/pix_data : incoming pixel
//   out_valid         : in_valid delayed one cycle
//   out_dark          : registered (luma < LUMA_TH), only set for valid pixels
module pix_classify
    import capiano_pkg::*;
#(
    parameter int LUMA_TH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             out_valid,
    output logic             out_dark
);

    logic [7:0] luma;

    assign luma = rgb565_luma(pix_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_dark  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_dark  <= in_valid && (int'(luma) < LUMA_TH);
        end
    end

endmodule

// File: rtl/key_detector.sv
// key_detector: counts dark pixels per key column inside the key band and
// publishes a hysteresis-debounced pressed mask at end of frame.
//   clk, rst : clock, async active-low reset
//   bus      : key_detector_if slave (pixel stream in, key results out)
//
// state    | meaning
// KD_IDLE  | no frame open, waiting for sof
// KD_COUNT | frame open, accumulating dark counts
// KD_EVAL  | one cycle: evaluate keys, publish, clear counters
module key_detector
    import capiano_pkg::*;
#(
    parameter int NUM_KEYS  = 8,
    parameter int KEY_W     = 80,
    parameter int ROW_START = 300,
    parameter int ROW_END   = 420,
    parameter int LUMA_TH   = 40,
    parameter int ON_TH     = 1200,
    parameter int OFF_TH    = 800
) (
    input  logic          clk,
    input  logic          rst,
    key_detector_if.slave bus
);

    localparam int          X_LIM_I  = (NUM_KEYS * KEY_W > 1024) ? 1024 : NUM_KEYS * KEY_W;
    localparam logic [10:0] X_LIM    = 11'(X_LIM_I);
    localparam logic [9:0]  ROW_LO   = 10'(ROW_START);
    localparam logic [9:0]  ROW_HI   = 10'(ROW_END);
    localparam logic [3:0]  KEY_LAST = 4'(NUM_KEYS - 1);
    localparam logic [9:0]  OFF_LAST = 10'(KEY_W - 1);
    localparam logic [15:0] ON_T     = 16'(ON_TH);
    localparam logic [15:0] OFF_T    = 16'(OFF_TH);

    // Stage 0: position of the current pixel. The counters hold the position
    // of the next pixel; sof overrides them to the origin.
    logic [9:0] x_cnt, y_cnt, koff_cnt;
    logic [3:0] kidx_cnt;
    logic [9:0] x_cur, y_cur, koff_cur;
    logic [3:0] kidx_cur;
    logic       in_win;

    always_comb begin
        x_cur    = bus.sof ? 10'd0 : x_cnt;
        y_cur    = bus.sof ? 10'd0 : y_cnt;
        koff_cur = bus.sof ? 10'd0 : koff_cnt;
        kidx_cur = bus.sof ? 4'd0  : kidx_cnt;
        in_win   = ({1'b0, x_cur} < X_LIM) && (y_cur >= ROW_LO) && (y_cur <= ROW_HI);
    end

    // Key index is tracked incrementally alongside x instead of dividing.
    // Past the last key it parks on KEY_LAST; those pixels fail the x window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            koff_cnt <= '0;
            kidx_cnt <= '0;
        end else if (bus.pix_valid) begin
            if (bus.eol) begin
                x_cnt    <= '0;
                koff_cnt <= '0;
                kidx_cnt <= '0;
                y_cnt    <= (y_cur == 10'h3FF) ? y_cur : y_cur + 10'd1;
            end else begin
                x_cnt <= (x_cur == 10'h3FF) ? x_cur : x_cur + 10'd1;
                y_cnt <= y_cur;
                if (koff_cur == OFF_LAST) begin
                    koff_cnt <= '0;
                    kidx_cnt <= (kidx_cur == KEY_LAST) ? kidx_cur : kidx_cur + 4'd1;
                end else begin
                    koff_cnt <= koff_cur + 10'd1;
                    kidx_cnt <= kidx_cur;
                end
            end
        end
    end

    // Stage 1: classified pixel plus its markers and key position.
    logic       s1_valid, s1_dark, s1_sof, s1_eof, s1_win;
    logic [3:0] s1_key;

    pix_classify #(.LUMA_TH(LUMA_TH)) u_classify (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.pix_valid),
        .pix_data  (bus.pix_data),
        .out_valid (s1_valid),
        .out_dark  (s1_dark)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_sof <= 1'b0;
            s1_eof <= 1'b0;
            s1_win <= 1'b0;
            s1_key <= '0;
        end else begin
            s1_sof <= bus.pix_valid & bus.sof;
            s1_eof <= bus.pix_valid & bus.eof;
            s1_win <= in_win;
            s1_key <= kidx_cur;
        end
    end

    // Stage 2: accumulate and evaluate.
    kd_state_t            state;
    logic [3:0]           frame_cnt;
    logic [15:0]          cnt     [NUM_KEYS];
    logic [15:0]          cnt_nxt [NUM_KEYS];
    logic                 frame_active, hit, restart;
    logic [NUM_KEYS-1:0]  eval_mask;
    logic [15:0]          best_cnt;
    logic [3:0]           best_idx;
    logic [3:0]           mask4;

    assign frame_active = (state == KD_COUNT);
    assign hit          = s1_valid && (s1_sof || frame_active) && s1_dark && s1_win;
    // EVAL clears the counters it has just read; a sof pixel in that same
    // cycle lands in the cleared set. A sof mid-frame discards partial counts.
    assign restart      = (state == KD_EVAL) || (s1_valid && s1_sof);

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_nxt[k] = restart ? 16'd0 : cnt[k];
            if (hit && (s1_key == 4'(k)) && (cnt_nxt[k] != 16'hFFFF))
                cnt_nxt[k] = cnt_nxt[k] + 16'd1;
        end
    end

    always_comb begin
        eval_mask = '0;
        best_cnt  = cnt[0];
        best_idx  = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            eval_mask[k] = bus.key_mask[k] ? (cnt[k] >= OFF_T) : (cnt[k] >= ON_T);
        // Strict compare keeps the lowest index on ties.
        for (int k = 1; k < NUM_KEYS; k++) begin
            if (cnt[k] > best_cnt) begin
                best_cnt = cnt[k];
                best_idx = 4'(k);
            end
        end
        mask4 = '0;
        for (int i = 0; i < 4; i++)
            if (i < NUM_KEYS) mask4[i] = eval_mask[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= KD_IDLE;
            frame_cnt     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
            bus.key_mask  <= '0;
            bus.key_onset <= '0;
            bus.key_valid <= 1'b0;
            bus.debug_out <= '0;
        end else begin
            bus.key_valid <= 1'b0;
            bus.key_onset <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= cnt_nxt[k];
            case (state)
                KD_IDLE: begin
                    if (s1_valid && s1_sof) state <= s1_eof ? KD_EVAL : KD_COUNT;
                end
                KD_COUNT: begin
                    if (s1_valid && s1_eof) state <= KD_EVAL;
                end
                KD_EVAL: begin
                    bus.key_mask  <= eval_mask;
                    bus.key_onset <= eval_mask & ~bus.key_mask;
                    bus.key_valid <= 1'b1;
                    frame_cnt     <= frame_cnt + 4'd1;
                    bus.debug_out <= {frame_cnt + 4'd1, 4'h0, best_idx, mask4};
                    if (s1_valid && s1_sof) state <= s1_eof ? KD_EVAL : KD_COUNT;
                    else                    state <= KD_IDLE;
                end
                default: state <= KD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_detector.sv
module tb_key_detector;
    import capiano_pkg::*;

    localparam int NK   = 4;
    localparam int KW   = 8;
    localparam int RS   = 4;
    localparam int RE   = 7;
    localparam int LT   = 40;
    localparam int ONT  = 20;
    localparam int OFFT = 12;
    localparam int W    = 40;
    localparam int H    = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_detector_if #(.NUM_KEYS(NK)) bus ();

    key_detector #(
        .NUM_KEYS(NK), .KEY_W(KW), .ROW_START(RS), .ROW_END(RE),
        .LUMA_TH(LT), .ON_TH(ONT), .OFF_TH(OFFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  onset;
        logic [15:0] dbg;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [3:0] exp_fc = 4'd0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops one expected publish per key_valid pulse.
    always @(negedge clk) begin
        if (bus.key_valid === 1'b1) begin
            if (prev_valid) begin
                n_chk++; n_fail++;
                $display("FAIL key_valid_width: high on consecutive cycles at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_publish: mask %h at cycle %0d, no publish expected", bus.key_mask, cyc);
            end else begin
                cur = sb.pop_front();
                check("key_mask",  32'(bus.key_mask),  32'(cur.mask));
                check("key_onset", 32'(bus.key_onset), 32'(cur.onset));
                check("debug_out", 32'(bus.debug_out), 32'(cur.dbg));
                check("latency",   32'(cyc),           32'(cur.cyc));
            end
        end else if (bus.key_onset !== '0) begin
            n_chk++; n_fail++;
            $display("FAIL onset_without_valid: onset %h at cycle %0d, expected 0", bus.key_onset, cyc);
        end
        prev_valid <= (bus.key_valid === 1'b1);
    end

    task automatic drive(input logic [15:0] d, input logic s, input logic l, input logic e);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.sof       = s;
        bus.eol       = l;
        bus.eof       = e;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0; bus.eol = 1'b0; bus.eof = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic expect_pub(input logic [3:0] m, input logic [3:0] o, input logic [3:0] mx);
        exp_t e;
        exp_fc  = exp_fc + 4'd1;
        e.mask  = m;
        e.onset = o;
        e.dbg   = {exp_fc, 4'h0, mx, m};
        e.cyc   = cyc + 3;
        sb.push_back(e);
    endtask

    // 0 all black, 1 all white, 2 first n band pixels of key 2 dark,
    // 3 dark only outside the window, 4 keys 1 and 3 dark, 5 luma threshold probes
    function automatic logic [15:0] pix_at(input int mode, input int n, input int x, input int y);
        int k;
        bit band;
        k    = x / KW;
        band = (y >= RS) && (y <= RE);
        case (mode)
            0: return 16'h0000;
            2: return (x >= 16 && x < 24 && band && ((y - RS) * KW + (x - 16)) < n) ? 16'h0000 : 16'hFFFF;
            3: return (x >= 32 || y < RS) ? 16'h0000 : 16'hFFFF;
            4: return (k == 1 || k == 3) ? 16'h0000 : 16'hFFFF;
            5: case (k)
                   0: return 16'h04E0;
                   1: return 16'h0500;
                   2: return 16'h9800;
                   3: return 16'hA000;
                   default: return 16'hFFFF;
               endcase
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic send_frame(input int mode, input int n, input int rows, input bit with_eof,
                              input logic [3:0] m, input logic [3:0] o, input logic [3:0] mx);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < W; x++) begin
                bit last;
                last = with_eof && (y == rows - 1) && (x == W - 1);
                drive(pix_at(mode, n, x, y), (x == 0 && y == 0), (x == W - 1), last);
                if (last) expect_pub(m, o, mx);
            end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.sof = 1'b0; bus.eol = 1'b0; bus.eof = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_mask",  32'(bus.key_mask),  32'h0);
        check("rst_onset", 32'(bus.key_onset), 32'h0);
        check("rst_valid", 32'(bus.key_valid), 32'h0);
        check("rst_debug", 32'(bus.debug_out), 32'h0);
        @(negedge clk) rst = 1'b1;
        idle(3);

        // Publish something, then reset mid-frame.
        send_frame(0, 0, H, 1'b1, 4'hF, 4'hF, 4'd0);
        idle(6);
        send_frame(0, 0, 6, 1'b0, 4'h0, 4'h0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.pix_valid = 1'b0;
        #1;
        check("midrst_mask",  32'(bus.key_mask),  32'h0);
        check("midrst_onset", 32'(bus.key_onset), 32'h0);
        check("midrst_valid", 32'(bus.key_valid), 32'h0);
        check("midrst_debug", 32'(bus.debug_out), 32'h0);
        exp_fc = 4'd0;
        idle(3);
        rst = 1'b1;
        idle(2);

        // Stream with eof but no sof must be ignored.
        for (int i = 0; i < 30; i++) drive(16'h0000, 1'b0, (i % 10 == 9), (i == 29));
        idle(10);

        send_frame(0, 0,  H, 1'b1, 4'hF, 4'hF, 4'd0); idle(5);
        send_frame(0, 0,  H, 1'b1, 4'hF, 4'h0, 4'd0); idle(5);
        send_frame(2, 16, H, 1'b1, 4'h4, 4'h0, 4'd2); idle(5);
        send_frame(2, 10, H, 1'b1, 4'h0, 4'h0, 4'd2); idle(5);
        send_frame(2, 20, H, 1'b1, 4'h4, 4'h4, 4'd2); idle(5);
        send_frame(2, 12, H, 1'b1, 4'h4, 4'h0, 4'd2); idle(5);
        send_frame(2, 11, H, 1'b1, 4'h0, 4'h0, 4'd2); idle(5);
        send_frame(3, 0,  H, 1'b1, 4'h0, 4'h0, 4'd0); idle(5);

        // Aborted dark frame restarted by a white frame.
        send_frame(0, 0, 9, 1'b0, 4'h0, 4'h0, 4'd0);
        send_frame(1, 0, H, 1'b1, 4'h0, 4'h0, 4'd0); idle(5);

        // Back-to-back frames, no gap.
        send_frame(0, 0, H, 1'b1, 4'hF, 4'hF, 4'd0);
        send_frame(1, 0, H, 1'b1, 4'h0, 4'h0, 4'd0); idle(5);

        // One-pixel frame.
        drive(16'h0000, 1'b1, 1'b1, 1'b1);
        expect_pub(4'h0, 4'h0, 4'd0);
        idle(6);

        send_frame(4, 0, H, 1'b1, 4'hA, 4'hA, 4'd1); idle(5);
        send_frame(5, 0, H, 1'b1, 4'h5, 4'h5, 4'd0); idle(5);
        send_frame(1, 0, H, 1'b1, 4'h0, 4'h0, 4'd0); idle(5);
        send_frame(1, 0, H, 1'b1, 4'h0, 4'h0, 4'd0); idle(5);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d publishes outstanding, expected 0", sb.size());
        end
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_detector.md
# key_detector

Finger-press detector for the camera piano. Sits directly downstream of the camera readout stage and consumes its RGB565 pixel stream. It counts dark (shadowed) pixels inside a horizontal key band for each of `NUM_KEYS` equal-width key columns. At end of frame it publishes a debounced pressed-key mask, per-key onset pulses and a debug word for the seven-segment display.

## Interface
Parameters:
- `NUM_KEYS`, 8: number of key columns, 1..16
- `KEY_W`, 80: key width in pixels; key k covers x in [k*KEY_W, (k+1)*KEY_W)
- `ROW_START`, 300: first row of the key band, inclusive
- `ROW_END`, 420: last row of the key band, inclusive
- `LUMA_TH`, 40: a pixel is dark when luma < `LUMA_TH`
- `ON_TH`, 1200: a key becomes pressed when its dark count >= `ON_TH`
- `OFF_TH`, 800: a key is released when its dark count < `OFF_TH`; `OFF_TH` <= `ON_TH`

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `rst` in 1: asynchronous, active-low reset.
- `pix_valid` in 1: `pix_data` is valid this cycle.
- `pix_data` in 16: RGB565 pixel, R = [15:11], G = [10:5], B = [4:0].
- `sof` in 1: start of frame; qualified by `pix_valid`; marks the first pixel of a frame.
- `eol` in 1: end of line; qualified by `pix_valid`; marks the last pixel of a line.
- `eof` in 1: end of frame; qualified by `pix_valid`; marks the last pixel of a frame.
- `key_mask` out `NUM_KEYS`: current pressed state, bit k = key k.
- `key_onset` out `NUM_KEYS`: one-cycle pulse for each key that went from released to pressed.
- `key_valid` out 1: one-cycle pulse when `key_mask` is updated.
- `debug_out` out 16: {frame_cnt[3:0], 4'h0, max_key_idx[3:0], key_mask[3:0]}.

## Operation
- Luma is computed as `(R<<1) + G + B`, 8 bits wide, range 0..156.
- A pixel is dark when luma < `LUMA_TH`.
- Position counters x (10-bit) and y (10-bit) advance only on `pix_valid`:
  - x increments per pixel and resets to 0 after an `eol` pixel.
  - y increments after each `eol` pixel.
  - `sof` forces the current pixel to x=0, y=0.
  - x saturates at 1023. y saturates at 1023.
- Key index comes from a running key_idx / in-key offset pair. No divider is used.
- Pixels with x >= `NUM_KEYS*KEY_W` are ignored.
- Pixels with y outside [`ROW_START`, `ROW_END`] are ignored.
- Each key has a 16-bit dark-pixel counter. It saturates at 0xFFFF and never wraps.
- `frame_active` is set by `sof` and cleared by `eof`.
  - Pixels arriving while `frame_active` = 0 and without `sof` are ignored.
  - An `eof` arriving while `frame_active` = 0 is ignored.
- A `sof` arriving mid-frame discards the partial counts: all counters restart, the sof pixel is counted, and nothing is published.
- On a valid `eof`:
  - The eof pixel is counted first.
  - Each key is then evaluated with hysteresis. A released key becomes pressed if count >= `ON_TH`. A pressed key becomes released if count < `OFF_TH`. Otherwise the key keeps its state.
  - All counters are cleared.
  - `frame_cnt` increments, wrapping mod 16.
  - `max_key_idx` is set to the index of the largest count; ties go to the lowest index.
- When `sof` and `eof` arrive on the same cycle, the pixel is treated as a one-pixel frame: it is counted, then the frame is published.
- State machine `IDLE -> COUNT -> EVAL -> IDLE`:
  - `IDLE`: waits for `sof`.
  - `COUNT`: accumulates dark counts.
  - `EVAL`: lasts one cycle and publishes results.
  - A `sof` arriving during `EVAL` is accepted, and its pixel goes to the freshly cleared counters.

## Timing
- Pixel to counter update: 2 cycles (luma/classify register, then accumulate).
- `eof` pixel to `key_valid` pulse: 3 cycles. `key_mask` and `key_onset` change on the same edge that `key_valid` rises.
- `key_onset` and `key_valid` are high for exactly one cycle.
- Full throughput: one pixel per cycle, no backpressure. Back-to-back frames with no gap are supported.
- Reset values: `key_mask` = 0, `key_onset` = 0, `key_valid` = 0, `debug_out` = 0. All counters = 0, `frame_active` = 0, state = `IDLE`.
- Reset mid-frame: everything returns to reset values immediately, and the next `sof` starts cleanly.

## Structure
- Shared `capiano_pkg` holds:
  - `PIX_W` = 16, `FRAME_W` = 640, `FRAME_H` = 480
  - the RGB565 field slice constants
  - state enum `kd_state_t`
- Sub-module `pix_classify` performs the registered RGB565-to-luma conversion and the dark compare (one pipeline stage). It is reusable by later colour-marker stages.

## Test plan
- Reset with `rst`=0 mid-stream -> all outputs 0. After release, no `key_valid` until a full sof..eof frame has been received.
- 640x480 frame, all pixels 0x0000, defaults -> each key counts 80*121 = 9680; 3 cycles after `eof`: `key_mask`=0xFF, `key_onset`=0xFF, `key_valid`=1 for 1 cycle.
- Same frame repeated -> `key_mask`=0xFF, `key_onset`=0x00.
- Frame with only key 2 dark, 1000 pixels, after key 2 was pressed -> `key_mask` bit 2 stays 1 (hysteresis: 800 <= 1000 < 1200). Next frame with 700 dark pixels -> bit 2 cleared.
- Dark pixels only at x >= 640 or rows 0..299 -> all counts 0, `key_mask`=0.
- `sof` reissued mid-frame after 5000 dark pixels, then a clean all-white frame -> no publish on the aborted frame; final `key_mask`=0, `frame_cnt` incremented by 1.
